// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, valid/ready word output.
// Define UART_RX_FRAMING_CHECK_EN to discard frames with a low stop bit and pulse framing_err.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int BITS_N       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_in,
    output logic [BITS_N-1:0] data_rx,
    output logic              valid,
    input  logic              ready,
    output logic              overrun,
    output logic              framing_err
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W = $clog2(BITS_N) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_e;

    state_e             state_q, state_d;
    logic               sync1_q, rx_s_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [BITS_N-1:0]  shift_q, shift_d, shift_in;
    logic [BITS_N-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               cnt_last;
    logic               stop_sample;
    logic               word_done;

    assign cnt_last    = (cnt_q == CNT_LAST);
    assign stop_sample = (state_q == STOP_BIT) && cnt_last;

    // New bit enters at the MSB so the first (LSB) bit ends up in bit 0.
    if (BITS_N == 1) begin : g_shift_one
        assign shift_in = rx_s_q;
    end else begin : g_shift_many
        assign shift_in = {rx_s_q, shift_q[BITS_N-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= uart_in;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!rx_s_q) state_d = START_BIT;
            START_BIT: if (cnt_q == CNT_HALF) state_d = rx_s_q ? IDLE : DATA_BITS;
            DATA_BITS: if (cnt_last && (bit_q == BIT_LAST)) state_d = STOP_BIT;
            STOP_BIT:  if (cnt_last) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            START_BIT: begin
                cnt_d = (cnt_q == CNT_HALF) ? '0 : cnt_q + CNT_W'(1);
            end
            DATA_BITS: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + BIT_W'(1);
                    shift_d = shift_in;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP_BIT: begin
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
            end
            default: begin
                cnt_d = '0;
                bit_d = '0;
            end
        endcase
    end

`ifdef UART_RX_FRAMING_CHECK_EN
    logic framing_q, framing_d;

    assign word_done = stop_sample && rx_s_q;

    always_comb begin
        framing_d = stop_sample && !rx_s_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            framing_q <= 1'b0;
        end else begin
            framing_q <= framing_d;
        end
    end

    assign framing_err = framing_q;
`else
    assign word_done   = stop_sample;
    assign framing_err = 1'b0;
`endif

    // A completion and an accept on the same edge reload the holding register.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = 1'b0;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (word_done) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_rx = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: one 8-bit/8-clk receiver and one 16-bit/5-clk receiver.
// Expected words (with their arrival cycle) are queued when a frame is driven and popped when valid loads.
module tb_uart_rx_core;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart8, uart16;
    logic        ready8, ready16;
    logic [7:0]  data8;
    logic [15:0] data16;
    logic        valid8, valid16;
    logic        ovr8, ovr16;
    logic        ferr8, ferr16;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q8[$];
    exp_t q16[$];
    int   ov_cnt8 = 0, ov_cyc8 = -1, ov_cnt16 = 0;
    int   fe_cnt8 = 0, fe_cyc8 = -1, fe_cnt16 = 0;

    uart_rx_core #(.CLKS_PER_BIT(8), .BITS_N(8)) dut8 (
        .clk         (clk),
        .reset       (rst),
        .uart_in     (uart8),
        .data_rx     (data8),
        .valid       (valid8),
        .ready       (ready8),
        .overrun     (ovr8),
        .framing_err (ferr8)
    );

    uart_rx_core #(.CLKS_PER_BIT(5), .BITS_N(16)) dut16 (
        .clk         (clk),
        .reset       (rst),
        .uart_in     (uart16),
        .data_rx     (data16),
        .valid       (valid16),
        .ready       (ready16),
        .overrun     (ovr16),
        .framing_err (ferr16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit is16, input logic v);
        if (is16) uart16 = v;
        else      uart8  = v;
    endtask

    // Drives start, data (LSB first) and stop; s is the edge at which the synchronizer sees the start bit.
    task automatic send(input bit is16, input logic [15:0] d, input logic stop_v,
                        input bit push, output int s);
        int   cpb;
        int   nb;
        exp_t e;
        cpb = is16 ? 5 : 8;
        nb  = is16 ? 16 : 8;
        drive(is16, 1'b0);
        s = cyc + 1;
        if (push) begin
            e.data = d;
            e.cyc  = s + 3 + cpb / 2 + (nb + 1) * cpb;
            if (is16) q16.push_back(e);
            else      q8.push_back(e);
        end
        repeat (cpb) tick();
        for (int i = 0; i < nb; i++) begin
            drive(is16, d[i]);
            repeat (cpb) tick();
        end
        drive(is16, stop_v);
        repeat (cpb) tick();
        drive(is16, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q8.size() != 0 || q16.size() != 0); i++) tick();
        check("drain_timeout", q8.size() + q16.size(), 0);
    endtask

    // Monitor: a new word is loaded when valid is high and was either low or accepted on the previous edge.
    initial begin
        logic pv8, pr8, pv16, pr16;
        exp_t e;
        pv8 = 1'b0; pr8 = 1'b0; pv16 = 1'b0; pr16 = 1'b0;
        forever begin
            @(negedge clk);
            if (valid8 && (!pv8 || pr8)) begin
                if (q8.size() == 0) begin
                    check("unexpected_valid8", data8, 32'hFFFF_FFFF);
                end else begin
                    e = q8.pop_front();
                    check("data8", data8, e.data);
                    check("cyc8", cyc, e.cyc);
                end
            end
            if (valid16 && (!pv16 || pr16)) begin
                if (q16.size() == 0) begin
                    check("unexpected_valid16", data16, 32'hFFFF_FFFF);
                end else begin
                    e = q16.pop_front();
                    check("data16", data16, e.data);
                    check("cyc16", cyc, e.cyc);
                end
            end
            if (ovr8)   begin ov_cnt8++; ov_cyc8 = cyc; end
            if (ovr16)  ov_cnt16++;
            if (ferr8)  begin fe_cnt8++; fe_cyc8 = cyc; end
            if (ferr16) fe_cnt16++;
            pv8 = valid8;   pr8 = ready8;
            pv16 = valid16; pr16 = ready16;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2;
        rst = 1'b1; uart8 = 1'b1; uart16 = 1'b1; ready8 = 1'b0; ready16 = 1'b0;
        repeat (3) tick();
        check("rst_data8", data8, 0);
        check("rst_valid8", valid8, 0);
        check("rst_ovr8", ovr8, 0);
        check("rst_ferr8", ferr8, 0);
        check("rst_data16", data16, 0);
        check("rst_valid16", valid16, 0);
        rst = 1'b0;
        repeat (5) tick();

        // Basic frame, consumer always ready: valid lasts one cycle.
        ready8 = 1'b1;
        send(1'b0, 16'h00A5, 1'b1, 1'b1, s);
        drain();
        check("t1_valid_one_cycle", valid8, 0);
        check("t1_ovr_none", ov_cnt8, 0);
        check("t1_ferr_none", fe_cnt8, 0);
        repeat (10) tick();

        // 3-cycle glitch must be rejected, then a good frame.
        uart8 = 1'b0;
        repeat (3) tick();
        uart8 = 1'b1;
        repeat (20) tick();
        check("t2_no_valid_after_glitch", valid8, 0);
        send(1'b0, 16'h003C, 1'b1, 1'b1, s);
        drain();
        repeat (10) tick();

        // Back-to-back frames with no consumer: second word dropped with one overrun pulse.
        ready8 = 1'b0;
        send(1'b0, 16'h0011, 1'b1, 1'b1, s);
        send(1'b0, 16'h0022, 1'b1, 1'b0, s2);
        tick();
        check("t3_ovr_count", ov_cnt8, 1);
        check("t3_ovr_cycle", ov_cyc8, s2 + 3 + 4 + 72);
        check("t3_valid_held", valid8, 1);
        check("t3_data_held", data8, 8'h11);
        ready8 = 1'b1;
        tick();
        ready8 = 1'b0;
        check("t3_valid_dropped", valid8, 0);
        check("t3_data_kept", data8, 8'h11);
        repeat (10) tick();

        // Stop bit driven low.
        ready8 = 1'b1;
`ifdef UART_RX_FRAMING_CHECK_EN
        send(1'b0, 16'h005A, 1'b0, 1'b0, s);
        tick();
        check("t4_ferr_count", fe_cnt8, 1);
        check("t4_ferr_cycle", fe_cyc8, s + 3 + 4 + 72);
        check("t4_valid_low", valid8, 0);
`else
        send(1'b0, 16'h005A, 1'b0, 1'b1, s);
        drain();
        check("t4_ferr_none", fe_cnt8, 0);
`endif
        repeat (20) tick();
        check("t4_ovr_unchanged", ov_cnt8, 1);

        // Reset in the middle of 0xFF while a word is held.
        ready8 = 1'b0;
        send(1'b0, 16'h0042, 1'b1, 1'b1, s);
        tick();
        check("t5_held_before_reset", valid8, 1);
        uart8 = 1'b0;
        repeat (8) tick();
        uart8 = 1'b1;
        repeat (8 * 4 + 3) tick();
        rst = 1'b1;
        #1;
        check("t5_rst_valid", valid8, 0);
        check("t5_rst_data", data8, 0);
        check("t5_rst_ovr", ovr8, 0);
        check("t5_rst_ferr", ferr8, 0);
        tick();
        rst = 1'b0;
        repeat (20) tick();
        ready8 = 1'b1;
        send(1'b0, 16'h0081, 1'b1, 1'b1, s);
        drain();
        repeat (10) tick();

        // Wide word on the 16-bit receiver.
        ready16 = 1'b1;
        send(1'b1, 16'hBEEF, 1'b1, 1'b1, s);
        drain();
        repeat (5) tick();
        check("t6_valid16_dropped", valid16, 0);
        check("ovr16_none", ov_cnt16, 0);
        check("ferr16_none", fe_cnt16, 0);
        check("ovr8_total", ov_cnt8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
